custom_slave_axi4_mem: RTL and testbench

AXI4 full-protocol memory-backed slave (responder) for the custom slave IP. It accepts INCR, FIXED and optionally WRAP bursts of up to 256 beats on independent write and read channels, and stores the data in an internal register array. It sits behind the interconnect in the block design, where the AXI VIP master exercises it with WRITE_BURST/READ_BURST sequences.

---
 rtl/custom_slave_axi4_pkg.sv | 44 ++++
 rtl/custom_slave_burst_addr.sv | 52 +++++
 rtl/custom_slave_axi4_mem.sv | 274 +++++++++++++++++++++++++++
 tb/tb_custom_slave_axi4_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_slave_axi4_pkg.sv
// Shared types and constants for the custom slave AXI4 memory.
// Build option: define CUSTOM_SLAVE_WRAP_EN to support WRAP bursts.
package custom_slave_axi4_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned CNT_W   = LEN_W + 1;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Burst shape latched from an address-channel handshake
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        burst_e            burst;
    } burst_ctl_t;

    // WRAP bursts must be 2, 4, 8 or 16 beats long
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/custom_slave_burst_addr.sv
// Combinational next-beat address and burst legality check.
// Build option: CUSTOM_SLAVE_WRAP_EN enables the wrap-window logic.
module custom_slave_burst_addr
    import custom_slave_axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ADDR_LSB   = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  burst_ctl_t            i_ctl,
    output logic [ADDR_WIDTH-1:0] o_next_addr_c,
    output logic                  o_err_c
);

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_incr;

    assign w_bytes = ADDR_WIDTH'(1) << i_ctl.size;
    assign w_incr  = i_addr + w_bytes;

`ifdef CUSTOM_SLAVE_WRAP_EN
    logic [31:0]           w_span;
    logic [ADDR_WIDTH-1:0] w_mask;

    // Wrap window is (len+1)*bytes, naturally aligned
    assign w_span = (32'(i_ctl.len) + 32'd1) << i_ctl.size;
    assign w_mask = ADDR_WIDTH'(w_span - 32'd1);
`endif

    // Select next address by burst type and flag illegal bursts
    always_comb begin
        o_next_addr_c = w_incr;
        o_err_c       = (i_ctl.size != SIZE_W'(ADDR_LSB));
        case (i_ctl.burst)
            BURST_FIXED: o_next_addr_c = i_addr;
            BURST_INCR:  o_next_addr_c = w_incr;
            BURST_WRAP: begin
`ifdef CUSTOM_SLAVE_WRAP_EN
                o_next_addr_c = (i_addr & ~w_mask) | (w_incr & w_mask);
                if (!wrap_len_ok(i_ctl.len)) begin
                    o_err_c = 1'b1;
                end
`else
                o_err_c = 1'b1;
`endif
            end
            BURST_RSVD:  o_err_c = 1'b1;
            default:     o_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/custom_slave_axi4_mem.sv
// AXI4 memory-backed slave with independent write and read burst engines.
// Build option: CUSTOM_SLAVE_WRAP_EN enables WRAP bursts (otherwise SLVERR).
module custom_slave_axi4_mem
    import custom_slave_axi4_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Write channel
    wstate_e               r_wstate, w_wstate_nxt;
    burst_ctl_t            r_wctl, w_wctl_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt, w_waddr_step;
    logic [CNT_W-1:0]      r_wbeat, w_wbeat_nxt;
    logic                  r_wovf, w_wovf_nxt;
    logic                  w_werr;
    logic                  w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic [ID_WIDTH-1:0]   w_bid_nxt;
    logic [RESP_W-1:0]     w_bresp_nxt;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_widx;

    // Read channel
    rstate_e               r_rstate, w_rstate_nxt;
    burst_ctl_t            r_rctl, w_rctl_nxt, w_ar_ctl, w_rsel_ctl;
    logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt, w_raddr_step, w_rsel_addr;
    logic [LEN_W-1:0]      r_rbeat, w_rbeat_nxt;
    logic                  w_rerr;
    logic                  w_ar_hs, w_r_hs;
    logic                  w_arready_nxt, w_rvalid_nxt, w_rlast_nxt;
    logic [ID_WIDTH-1:0]   w_rid_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt, w_rd_word;
    logic [RESP_W-1:0]     w_rresp_nxt;
    logic [IDX_W-1:0]      w_ridx;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID & WREADY;
    assign w_b_hs  = BVALID & BREADY;
    assign w_ar_hs = ARVALID & ARREADY;
    assign w_r_hs  = RVALID & RREADY;

    assign w_widx  = r_waddr[ADDR_LSB +: IDX_W];

    assign w_ar_ctl.len   = ARLEN;
    assign w_ar_ctl.size  = ARSIZE;
    assign w_ar_ctl.burst = burst_e'(ARBURST);

    // Read engine sees the AR inputs while idle so the first beat can be fetched on the handshake
    assign w_rsel_addr = (r_rstate == R_IDLE) ? ARADDR   : r_raddr;
    assign w_rsel_ctl  = (r_rstate == R_IDLE) ? w_ar_ctl : r_rctl;
    assign w_ridx      = (r_rstate == R_IDLE) ? ARADDR[ADDR_LSB +: IDX_W]
                                              : w_raddr_step[ADDR_LSB +: IDX_W];
    assign w_rd_word   = r_mem[w_ridx];

    custom_slave_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_LSB   (ADDR_LSB)
    ) u_waddr (
        .i_addr        (r_waddr),
        .i_ctl         (r_wctl),
        .o_next_addr_c (w_waddr_step),
        .o_err_c       (w_werr)
    );

    custom_slave_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_LSB   (ADDR_LSB)
    ) u_raddr (
        .i_addr        (w_rsel_addr),
        .i_ctl         (w_rsel_ctl),
        .o_next_addr_c (w_raddr_step),
        .o_err_c       (w_rerr)
    );

    // Write FSM next-state and output logic
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wctl_nxt   = r_wctl;
        w_waddr_nxt  = r_waddr;
        w_wbeat_nxt  = r_wbeat;
        w_wovf_nxt   = r_wovf;
        w_bid_nxt    = BID;
        w_bresp_nxt  = BRESP;
        w_mem_we     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_wctl_nxt.len   = AWLEN;
                    w_wctl_nxt.size  = AWSIZE;
                    w_wctl_nxt.burst = burst_e'(AWBURST);
                    w_waddr_nxt      = AWADDR;
                    w_wbeat_nxt      = '0;
                    w_wovf_nxt       = 1'b0;
                    w_bid_nxt        = AWID;
                    w_wstate_nxt     = W_DATA;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    // Beats beyond len+1 are dropped and flag SLVERR; WLAST alone ends the burst
                    if (r_wbeat <= {1'b0, r_wctl.len}) begin
                        w_mem_we    = ~w_werr;
                        w_wbeat_nxt = r_wbeat + CNT_W'(1);
                    end else begin
                        w_wovf_nxt  = 1'b1;
                    end
                    w_waddr_nxt = w_waddr_step;
                    if (WLAST) begin
                        w_bresp_nxt  = (w_werr || w_wovf_nxt) ? RESP_SLVERR : RESP_OKAY;
                        w_wstate_nxt = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE);
        w_wready_nxt  = (w_wstate_nxt == W_DATA);
        w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
    end

    // Write FSM state and registered outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate <= W_IDLE;
            r_wctl   <= '0;
            r_waddr  <= '0;
            r_wbeat  <= '0;
            r_wovf   <= 1'b0;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= '0;
            BRESP    <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wctl   <= w_wctl_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wbeat  <= w_wbeat_nxt;
            r_wovf   <= w_wovf_nxt;
            AWREADY  <= w_awready_nxt;
            WREADY   <= w_wready_nxt;
            BVALID   <= w_bvalid_nxt;
            BID      <= w_bid_nxt;
            BRESP    <= w_bresp_nxt;
        end
    end

    // Storage array: byte-enabled write port, contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    r_mem[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next-state and output logic
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rctl_nxt   = r_rctl;
        w_raddr_nxt  = r_raddr;
        w_rbeat_nxt  = r_rbeat;
        w_rid_nxt    = RID;
        w_rdata_nxt  = RDATA;
        w_rresp_nxt  = RRESP;
        w_rlast_nxt  = RLAST;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rctl_nxt   = w_ar_ctl;
                    w_raddr_nxt  = ARADDR;
                    w_rbeat_nxt  = '0;
                    w_rid_nxt    = ARID;
                    w_rdata_nxt  = w_rerr ? '0 : w_rd_word;
                    w_rresp_nxt  = w_rerr ? RESP_SLVERR : RESP_OKAY;
                    w_rlast_nxt  = (ARLEN == '0);
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (RLAST) begin
                        w_rstate_nxt = R_IDLE;
                    end else begin
                        w_raddr_nxt = w_raddr_step;
                        w_rbeat_nxt = r_rbeat + LEN_W'(1);
                        w_rdata_nxt = w_rerr ? '0 : w_rd_word;
                        w_rresp_nxt = w_rerr ? RESP_SLVERR : RESP_OKAY;
                        w_rlast_nxt = ((r_rbeat + LEN_W'(1)) == r_rctl.len);
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rstate_nxt == R_DATA);
    end

    // Read FSM state and registered outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rctl   <= '0;
            r_raddr  <= '0;
            r_rbeat  <= '0;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rctl   <= w_rctl_nxt;
            r_raddr  <= w_raddr_nxt;
            r_rbeat  <= w_rbeat_nxt;
            ARREADY  <= w_arready_nxt;
            RVALID   <= w_rvalid_nxt;
            RLAST    <= w_rlast_nxt;
            RID      <= w_rid_nxt;
            RDATA    <= w_rdata_nxt;
            RRESP    <= w_rresp_nxt;
        end
    end

endmodule

// File: tb/tb_custom_slave_axi4_mem.sv
// Directed bench for custom_slave_axi4_mem (32-bit data, 1-bit IDs).
// Expectations follow CUSTOM_SLAVE_WRAP_EN for the WRAP step.
module tb_custom_slave_axi4_mem;

    localparam logic [1:0] B_FIX  = 2'b00;
    localparam logic [1:0] B_INCR = 2'b01;
    localparam logic [1:0] B_WRAP = 2'b10;
    localparam logic [1:0] B_RSVD = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  AWID, ARID, BID, RID;
    logic [9:0]  AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    int checks = 0;
    int failures = 0;
    logic [31:0] wd [16];
    logic [31:0] ed [16];

    always #5 ACLK = ~ACLK;

    custom_slave_axi4_mem dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_awready"}, AWREADY, 1'b0);
        chk1({tag, "_wready"},  WREADY,  1'b0);
        chk1({tag, "_bvalid"},  BVALID,  1'b0);
        chk1({tag, "_arready"}, ARREADY, 1'b0);
        chk1({tag, "_rvalid"},  RVALID,  1'b0);
        chk1({tag, "_rlast"},   RLAST,   1'b0);
        chk1({tag, "_bid"},     BID,     1'b0);
        chk2({tag, "_bresp"},   BRESP,   2'b00);
        chk1({tag, "_rid"},     RID,     1'b0);
        chk32({tag, "_rdata"},  RDATA,   32'h0);
        chk2({tag, "_rresp"},   RRESP,   2'b00);
    endtask

    // Called at a negedge; returns at the negedge after the AW handshake
    task automatic aw_send(input logic id, input logic [9:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk1("awready_wait", AWREADY, 1'b1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        chk1("wready_after_aw", WREADY, 1'b1);
        chk1("awready_busy", AWREADY, 1'b0);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        chk1("wready_wait", WREADY, 1'b1);
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic wr_burst(input logic id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nb,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n = 0;
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i < nb; i++) w_beat(wd[i], strb, (i == nb - 1));
        chk1("bvalid_after_wlast", BVALID, 1'b1);
        BREADY = 1'b1;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk1("bid", BID, id);
        chk2("bresp", BRESP, exp_resp);
        @(negedge ACLK);
        BREADY = 1'b0;
        chk1("bvalid_cleared", BVALID, 1'b0);
        chk1("awready_after_b", AWREADY, 1'b1);
    endtask

    // rr_pat[cycle % 4] drives RREADY each cycle of the data phase
    task automatic rd_burst(input logic id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] rr_pat, input logic [1:0] exp_resp);
        int n = 0;
        int beat = 0;
        int cyc = 0;
        int nb = int'(len) + 1;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk1("arready_wait", ARREADY, 1'b1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk1("rvalid_after_ar", RVALID, 1'b1);
        chk1("arready_busy", ARREADY, 1'b0);
        while (beat < nb && cyc < 200) begin
            RREADY = rr_pat[cyc % 4];
            chk1("rvalid", RVALID, 1'b1);
            chk32("rdata", RDATA, ed[beat]);
            chk2("rresp", RRESP, exp_resp);
            chk1("rlast", RLAST, (beat == nb - 1));
            chk1("rid", RID, id);
            if (RREADY) beat++;
            cyc++;
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        chk1("rd_all_beats", (beat == nb), 1'b1);
        chk1("rvalid_after_last", RVALID, 1'b0);
        chk1("arready_after_last", ARREADY, 1'b1);
    endtask

    initial begin
        ARESETN = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk_reset("por");
        ARESETN = 1'b1;
        #1;
        chk1("awready_before_edge", AWREADY, 1'b0);
        @(negedge ACLK);
        chk1("awready_first_edge", AWREADY, 1'b1);
        chk1("arready_first_edge", ARREADY, 1'b1);

        // Partial strobe over a zeroed word
        wd[0] = 32'h0;
        wr_burst(1'b0, 10'h010, 8'd0, 3'd2, B_INCR, 1, 4'hF, OKAY);
        wd[0] = 32'hDEADBEEF;
        wr_burst(1'b0, 10'h010, 8'd0, 3'd2, B_INCR, 1, 4'h3, OKAY);
        ed[0] = 32'h0000BEEF;
        rd_burst(1'b0, 10'h010, 8'd0, 3'd2, B_INCR, 4'b1111, OKAY);

        // INCR 8 beats, then read back streaming and with RREADY stalls
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ed[i] = 32'(i + 1); end
        wr_burst(1'b0, 10'h000, 8'd7, 3'd2, B_INCR, 8, 4'hF, OKAY);
        rd_burst(1'b0, 10'h000, 8'd7, 3'd2, B_INCR, 4'b1111, OKAY);
        rd_burst(1'b1, 10'h000, 8'd7, 3'd2, B_INCR, 4'b1001, OKAY);

        // FIXED burst keeps hitting one word
        wd[0] = 32'h1111_0001; wd[1] = 32'h2222_0002;
        wr_burst(1'b1, 10'h030, 8'd1, 3'd2, B_FIX, 2, 4'hF, OKAY);
        ed[0] = 32'h2222_0002; ed[1] = 32'h2222_0002;
        rd_burst(1'b0, 10'h030, 8'd1, 3'd2, B_FIX, 4'b1111, OKAY);

        // Extra beats past AWLEN+1: SLVERR and not written
        for (int i = 0; i < 3; i++) wd[i] = 32'h0;
        wr_burst(1'b0, 10'h038, 8'd2, 3'd2, B_INCR, 3, 4'hF, OKAY);
        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3;
        wr_burst(1'b0, 10'h038, 8'd1, 3'd2, B_INCR, 3, 4'hF, SLVERR);
        ed[0] = 32'hA1; ed[1] = 32'hA2; ed[2] = 32'h0;
        rd_burst(1'b0, 10'h038, 8'd2, 3'd2, B_INCR, 4'b1111, OKAY);

        // Narrow size is illegal on both channels
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        wr_burst(1'b0, 10'h020, 8'd3, 3'd2, B_INCR, 4, 4'hF, OKAY);
        for (int i = 0; i < 4; i++) wd[i] = 32'hEEEE_EEEE;
        wr_burst(1'b0, 10'h020, 8'd3, 3'd1, B_INCR, 4, 4'hF, SLVERR);
        ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33; ed[3] = 32'h44;
        rd_burst(1'b0, 10'h020, 8'd3, 3'd2, B_INCR, 4'b1111, OKAY);
        for (int i = 0; i < 4; i++) ed[i] = 32'h0;
        rd_burst(1'b0, 10'h020, 8'd3, 3'd1, B_INCR, 4'b1111, SLVERR);
        rd_burst(1'b1, 10'h020, 8'd1, 3'd2, B_RSVD, 4'b1111, SLVERR);

        // WRAP 4 beats from 0x08 over words holding 1..4
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
`ifdef CUSTOM_SLAVE_WRAP_EN
        wr_burst(1'b0, 10'h008, 8'd3, 3'd2, B_WRAP, 4, 4'hF, OKAY);
        ed[0] = 32'hC; ed[1] = 32'hD; ed[2] = 32'hA; ed[3] = 32'hB;
        rd_burst(1'b0, 10'h000, 8'd3, 3'd2, B_INCR, 4'b1111, OKAY);
        ed[0] = 32'hA; ed[1] = 32'hB; ed[2] = 32'hC; ed[3] = 32'hD;
        rd_burst(1'b0, 10'h008, 8'd3, 3'd2, B_WRAP, 4'b1111, OKAY);
`else
        wr_burst(1'b0, 10'h008, 8'd3, 3'd2, B_WRAP, 4, 4'hF, SLVERR);
        ed[0] = 32'h1; ed[1] = 32'h2; ed[2] = 32'h3; ed[3] = 32'h4;
        rd_burst(1'b0, 10'h000, 8'd3, 3'd2, B_INCR, 4'b1111, OKAY);
        for (int i = 0; i < 4; i++) ed[i] = 32'h0;
        rd_burst(1'b0, 10'h008, 8'd3, 3'd2, B_WRAP, 4'b1111, SLVERR);
`endif

        // Reset after beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) wd[i] = 32'h5A00_0000 + 32'(i);
        wr_burst(1'b0, 10'h080, 8'd7, 3'd2, B_INCR, 8, 4'hF, OKAY);
        aw_send(1'b1, 10'h080, 8'd7, 3'd2, B_INCR);
        for (int i = 0; i < 3; i++) w_beat(32'hC000_0000 + 32'(i), 4'hF, 1'b0);
        ARESETN = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        chk1("awready_rel_before_edge", AWREADY, 1'b0);
        @(negedge ACLK);
        chk1("awready_rel_first_edge", AWREADY, 1'b1);
        chk1("wready_rel_idle", WREADY, 1'b0);
        for (int i = 0; i < 8; i++) ed[i] = (i < 3) ? (32'hC000_0000 + 32'(i)) : (32'h5A00_0000 + 32'(i));
        rd_burst(1'b0, 10'h080, 8'd7, 3'd2, B_INCR, 4'b1111, OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
